// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : LEG decode stage. A DEPTH-entry {inst, pc} FIFO absorbs fetch
//               pulses (no backpressure) and the head entry is decoded for
//               execute. Optional macro DECODE_ILLEGAL_EN enables o_illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_inst,
    input  logic        i_inst_ready,
    input  logic [31:0] i_pc,
    input  logic        i_stall,
    input  logic        i_flush,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [5:0]  o_opcode,
    output logic [4:0]  o_rd,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [31:0] o_imm,
    output logic        o_rtype,
    output logic        o_overflow,
    output logic        o_illegal
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LDB  = 6'h09;
    localparam logic [5:0] OP_STB  = 6'h0A;
    localparam logic [5:0] OP_BEQ  = 6'h10;
    localparam logic [5:0] OP_JMP  = 6'h11;

    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;

    logic             valid;
    logic             full;
    logic             pop;
    logic             push;
    logic [31:0]      head_inst;
    logic [31:0]      head_pc;
    logic [5:0]       head_op;

    assign valid     = (count != '0);
    assign full      = (count == FULL_COUNT);
    assign pop       = valid && !i_stall;
    // A full buffer still accepts a pulse when the head leaves on the same edge.
    assign push      = i_inst_ready && (!full || pop);
    assign head_inst = inst_mem[rd_ptr];
    assign head_pc   = pc_mem[rd_ptr];
    assign head_op   = head_inst[31:26];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (i_flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (i_inst_ready && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage is intentionally not reset; o_valid masks stale contents.
    always_ff @(posedge i_clk) begin
        if (push && !i_flush && i_rst_n) begin
            inst_mem[wr_ptr] <= i_inst;
            pc_mem[wr_ptr]   <= i_pc;
        end
    end

    always_comb begin
        o_valid  = valid;
        o_pc     = '0;
        o_opcode = '0;
        o_rd     = '0;
        o_rs1    = '0;
        o_rs2    = '0;
        o_imm    = '0;
        o_rtype  = 1'b0;
        if (valid) begin
            o_pc     = head_pc;
            o_opcode = head_op;
            o_rd     = head_inst[25:21];
            o_rs1    = head_inst[20:16];
            o_rs2    = head_inst[15:11];
            case (head_op)
                OP_ADD, OP_SUB, OP_AND, OP_OR: o_rtype = 1'b1;
                OP_ADDI, OP_LDB, OP_STB, OP_BEQ:
                    o_imm = {{16{head_inst[15]}}, head_inst[15:0]};
                OP_JMP:
                    o_imm = {{6{head_inst[25]}}, head_inst[25:0]};
                default: o_imm = '0;
            endcase
        end
    end

    assign o_overflow = overflow;

`ifdef DECODE_ILLEGAL_EN
    logic op_known;

    always_comb begin
        op_known = 1'b0;
        case (head_op)
            OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ADDI, OP_LDB, OP_STB, OP_BEQ, OP_JMP: op_known = 1'b1;
            default:                                 op_known = 1'b0;
        endcase
    end

    assign o_illegal = valid && !op_known;
`else
    assign o_illegal = 1'b0;
`endif

endmodule
`default_nettype wire
